// File: rtl/seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// seg7_scan_driver
//
// Multiplexed N-digit 7-segment scan driver. Each digit is lit for
// REFRESH_DIV clk cycles in turn (digit 0 first). Hex nibbles are decoded to
// segments. Each digit has its own decimal point and blank control.
//
// New display content is written into a shadow register. The shadow is copied
// into the active set only at the frame wrap (digit NDIG-1 -> 0). Because of
// this, a frame never shows a mix of old and new digits.
//
// Optional feature (compile-time macro SEG7_BLINK_EN):
//   Adds the 'blink' input and the BLINK_FRAMES parameter. A blink phase
//   toggles every BLINK_FRAMES frames. While the phase is 1, each digit with
//   its blink bit set is dark.
//
// Parameters:
//   NDIG         digits scanned (1..8)
//   REFRESH_DIV  clk cycles each digit stays lit (>=1)
//   ACTIVE_LOW   1: an/cat active-low, 0: active-high
//   BLINK_FRAMES frames per blink half-period (SEG7_BLINK_EN only)
//
// Ports:
//   clk    system clock
//   rest   synchronous reset, active-high
//   en     1 = scan running; 0 = display dark, counters frozen
//   load   1-cycle strobe; captures data/dp/blank(/blink) into the shadow
//   data   hex nibbles; digit k = data[4k+3:4k]
//   dp     decimal point per digit (1 = lit)
//   blank  1 = digit k dark
//   blink  1 = digit k blinks (SEG7_BLINK_EN only)
//   an     anode drives, registered, one-hot (one-cold if ACTIVE_LOW)
//   cat    cathodes {dp,g,f,e,d,c,b,a}, registered
//   frame  1-cycle pulse after the scan wraps from digit NDIG-1 to 0
//   pend   1 = shadow holds data not yet applied
// ----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int NDIG         = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter bit ACTIVE_LOW   = 1'b1
`ifdef SEG7_BLINK_EN
  , parameter int BLINK_FRAMES = 64
`endif
) (
  input  logic                 clk,
  input  logic                 rest,
  input  logic                 en,
  input  logic                 load,
  input  logic [4*NDIG-1:0]    data,
  input  logic [NDIG-1:0]      dp,
  input  logic [NDIG-1:0]      blank,
`ifdef SEG7_BLINK_EN
  input  logic [NDIG-1:0]      blink,
`endif
  output logic [NDIG-1:0]      an,
  output logic [7:0]           cat,
  output logic                 frame,
  output logic                 pend
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]   IDX_MAX = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_OFF  = {NDIG{ACTIVE_LOW}};
  localparam logic [7:0]      CAT_OFF = {8{ACTIVE_LOW}};

  // One complete set of display content. The same layout is used for the
  // incoming inputs, the shadow set and the active set.
  typedef struct packed {
`ifdef SEG7_BLINK_EN
    logic [NDIG-1:0]   blink;
`endif
    logic [NDIG-1:0]   blank;
    logic [NDIG-1:0]   dp;
    logic [4*NDIG-1:0] data;
  } disp_t;

  disp_t           incoming;
  disp_t           shadow;
  disp_t           active;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   idx;
  logic            tick;
  logic            wrap;
  logic            dark;
  logic [3:0]      nib;
  logic [7:0]      seg;
  logic [NDIG-1:0] onehot;
  logic [NDIG-1:0] an_d;
  logic [7:0]      cat_d;

  // Segment pattern in active-high form, bit order gfedcba.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef SEG7_BLINK_EN
  assign incoming = {blink, blank, dp, data};
`else
  assign incoming = {blank, dp, data};
`endif

  assign tick = en && (cnt == CNT_MAX);
  assign wrap = tick && (idx == IDX_MAX);

  // Prescaler and digit index. Both hold their value while en is low, so the
  // scan resumes exactly where it stopped.
  // NOTE: every register here uses non-blocking assignments, so all of them
  // update from the same pre-edge values no matter what order they are written in.
  always_ff @(posedge clk) begin
    if (rest) begin
      cnt   <= '0;
      idx   <= '0;
      frame <= 1'b0;
    end else begin
      frame <= wrap;
      if (en) begin
        cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
        if (tick) begin
          idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
        end
      end
    end
  end

  // Shadow / active handoff. The active set changes only on a wrap tick. If a
  // load arrives in the same cycle as the wrap tick, it goes straight to the
  // active set and never shows up as pending.
  // NOTE: the display sets are cleared on reset like any other state, so the
  // display after reset shows all '0' digits and never X patterns.
  always_ff @(posedge clk) begin
    if (rest) begin
      active <= '0;
      shadow <= '0;
      pend   <= 1'b0;
    end else if (wrap) begin
      if (load) begin
        active <= incoming;
      end else if (pend) begin
        active <= shadow;
      end
      pend <= 1'b0;
    end else if (load) begin
      shadow <= incoming;
      pend   <= 1'b1;
    end
  end

`ifdef SEG7_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_FRAMES - 1);

  logic [BW-1:0] bcnt;
  logic          phase;

  // Counts frames. The phase flips after every BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (rest) begin
      bcnt  <= '0;
      phase <= 1'b0;
    end else if (wrap) begin
      if (bcnt == BCNT_MAX) begin
        bcnt  <= '0;
        phase <= ~phase;
      end else begin
        bcnt <= bcnt + 1'b1;
      end
    end
  end

  assign dark = active.blank[idx] | (active.blink[idx] & phase);
`else
  assign dark = active.blank[idx];
`endif

  // Next values of the pin outputs, built from the current digit index.
  // NOTE: every variable gets a default at the top of the block. This keeps
  // the block purely combinational, so no latch is inferred.
  always_comb begin
    an_d   = AN_OFF;
    cat_d  = CAT_OFF;
    onehot = '0;
    nib    = active.data[{idx, 2'b00} +: 4];
    seg    = {active.dp[idx], hex7(nib)};
    if (en && !dark) begin
      onehot[idx] = 1'b1;
      an_d        = ACTIVE_LOW ? ~onehot : onehot;
      cat_d       = ACTIVE_LOW ? ~seg : seg;
    end
  end

  // Register the outputs so the pins are glitch-free.
  always_ff @(posedge clk) begin
    if (rest) begin
      an  <= AN_OFF;
      cat <= CAT_OFF;
    end else begin
      an  <= an_d;
      cat <= cat_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Self-checking bench for seg7_scan_driver (NDIG=4, REFRESH_DIV=4,
// ACTIVE_LOW=1; BLINK_FRAMES=2 when SEG7_BLINK_EN is defined).
//
// A model counts enabled cycles since reset. From that count it derives the
// lit digit and the frame boundaries, and it keeps the shadow/active content.
// Its expected outputs are compared with the DUT on every falling edge.
// Directed sequences add hand-computed checks that pin the model down.
// ----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int NDIG   = 4;
  localparam int DIV    = 4;
  localparam int PERIOD = NDIG * DIV;
  localparam int BF     = 2;

  logic        clk = 1'b0;
  logic        rest, en, load;
  logic [15:0] data;
  logic [3:0]  dp, blank, blink;
  logic [3:0]  an;
  logic [7:0]  cat;
  logic        frame, pend;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

`ifdef SEG7_BLINK_EN
  seg7_scan_driver #(.NDIG(NDIG), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rest(rest), .en(en), .load(load), .data(data), .dp(dp),
    .blank(blank), .blink(blink), .an(an), .cat(cat), .frame(frame), .pend(pend));
`else
  seg7_scan_driver #(.NDIG(NDIG), .REFRESH_DIV(DIV), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rest(rest), .en(en), .load(load), .data(data), .dp(dp),
    .blank(blank), .an(an), .cat(cat), .frame(frame), .pend(pend));
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Digit-to-segment table: active-high gfedcba.
  function automatic logic [6:0] seg_of(input logic [3:0] v);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[v];
  endfunction

  // ---------------- model ----------------
  int          run;       // enabled cycles since reset
  int          frames;    // wraps since reset
  bit          started = 1'b0;
  logic [15:0] m_data, s_data;
  logic [3:0]  m_dp, s_dp, m_blank, s_blank, m_blink, s_blink;
  bit          s_pend;
  logic [3:0]  exp_an;
  logic [7:0]  exp_cat;
  logic        exp_frame, exp_pend;

  always @(posedge clk) begin : model
    int         d;
    bit         dk, wr;
    logic [7:0] s;
    logic [3:0] oh;
    if (rest) begin
      run = 0; frames = 0; s_pend = 0;
      m_data = '0; m_dp = '0; m_blank = '0; m_blink = '0;
      s_data = '0; s_dp = '0; s_blank = '0; s_blink = '0;
      exp_an = 4'hF; exp_cat = 8'hFF; exp_frame = 1'b0; exp_pend = 1'b0;
      started = 1'b1;
    end else begin
      d  = (run / DIV) % NDIG;
      dk = m_blank[d];
`ifdef SEG7_BLINK_EN
      if (m_blink[d] && ((frames / BF) % 2 == 1)) dk = 1'b1;
`endif
      if (!en || dk) begin
        exp_an  = 4'hF;
        exp_cat = 8'hFF;
      end else begin
        oh      = 4'b0001 << d;
        exp_an  = ~oh;
        s       = {m_dp[d], seg_of(m_data[4*d +: 4])};
        exp_cat = ~s;
      end
      wr = en && (run % PERIOD == PERIOD - 1);
      exp_frame = wr;
      if (en) run++;
      if (wr) begin
        frames++;
        if (load) begin
          m_data = data; m_dp = dp; m_blank = blank; m_blink = blink;
        end else if (s_pend) begin
          m_data = s_data; m_dp = s_dp; m_blank = s_blank; m_blink = s_blink;
        end
        s_pend = 0;
      end else if (load) begin
        s_data = data; s_dp = dp; s_blank = blank; s_blink = blink; s_pend = 1;
      end
      exp_pend = s_pend;
    end
  end

  // Compare process: check every cycle once the model has seen reset.
  always @(negedge clk) begin
    if (started) begin
      check("an", {28'd0, an}, {28'd0, exp_an});
      check("cat", {24'd0, cat}, {24'd0, exp_cat});
      check("frame", {31'd0, frame}, {31'd0, exp_frame});
      check("pend", {31'd0, pend}, {31'd0, exp_pend});
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_frame(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame !== 1'b1 && n < budget);
    if (frame !== 1'b1) begin
      tests++; fails++;
      $display("FAIL frame_timeout: no frame pulse within %0d cycles", budget);
    end
  endtask

  task automatic wait_an(input logic [3:0] v, input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (an !== v && n < budget);
    if (an !== v) begin
      tests++; fails++;
      $display("FAIL an_timeout: an never reached %b within %0d cycles", v, budget);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                         input logic [3:0] k);
    data = d; dp = p; blank = b; blink = k; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  logic [7:0] slot_cat [4] = '{8'hC0, 8'hB0, 8'h08, 8'hF9};
  logic [3:0] e_an;
  int         cnt_a, cnt_b;

  initial begin
    rest = 1'b1; en = 1'b1; load = 1'b0;
    data = '0; dp = '0; blank = '0; blink = '0;

    // 1: reset values, then scan order and frame rate
    repeat (2) @(negedge clk);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_cat", {24'd0, cat}, 32'hFF);
    check("rst_pend", {31'd0, pend}, 32'd0);
    rest = 1'b0;
    @(negedge clk);
    check("first_an", {28'd0, an}, 32'hE);
    check("first_cat", {24'd0, cat}, 32'hC0);
    wait_frame(40);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e_an = ~(4'b0001 << (i / 4));
      check("scan_an", {28'd0, an}, {28'd0, e_an});
      check("scan_frame", {31'd0, frame}, (i == 15) ? 32'd1 : 32'd0);
    end

    // 2: mid-frame load held until the wrap
    repeat (5) @(negedge clk);
    do_load(16'h1A30, 4'b0100, 4'b0000, 4'b0000);
    check("load_pend", {31'd0, pend}, 32'd1);
    check("load_old_cat", {24'd0, cat}, 32'hC0);
    wait_frame(40);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e_an = ~(4'b0001 << (i / 4));
      check("new_an", {28'd0, an}, {28'd0, e_an});
      check("new_cat", {24'd0, cat}, {24'd0, slot_cat[i / 4]});
      check("new_pend", {31'd0, pend}, 32'd0);
    end

    // 3: newest load wins; a load on the wrap tick goes straight to active
    repeat (2) @(negedge clk);
    do_load(16'h1111, 4'b0000, 4'b0000, 4'b0000);
    repeat (2) @(negedge clk);
    do_load(16'h2222, 4'b0000, 4'b0000, 4'b0000);
    wait_frame(40);
    @(negedge clk);
    check("last_load_an", {28'd0, an}, 32'hE);
    check("last_load_cat", {24'd0, cat}, 32'hA4);
    check("last_load_pend", {31'd0, pend}, 32'd0);
    repeat (14) @(negedge clk);
    do_load(16'h5678, 4'b0000, 4'b0000, 4'b0000);
    check("wrap_load_frame", {31'd0, frame}, 32'd1);
    check("wrap_load_pend", {31'd0, pend}, 32'd0);
    @(negedge clk);
    check("wrap_load_cat", {24'd0, cat}, 32'h80);
    check("wrap_load_pend2", {31'd0, pend}, 32'd0);

    // 5: pause mid-slot, resume with the remaining count
    wait_an(4'b1101, 40);
    @(negedge clk);
    en = 1'b0;
    cnt_a = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check("pause_an", {28'd0, an}, 32'hF);
        check("pause_cat", {24'd0, cat}, 32'hFF);
      end
      if (frame) cnt_a++;
    end
    check("pause_frames", cnt_a, 0);
    en = 1'b1;
    @(negedge clk);
    check("resume_an", {28'd0, an}, 32'hD);
    check("resume_cat", {24'd0, cat}, 32'hF8);
    @(negedge clk);
    check("resume_an2", {28'd0, an}, 32'hD);
    @(negedge clk);
    check("resume_an3", {28'd0, an}, 32'hB);

    // 4: blank digit 1
    do_load(16'h5678, 4'b0000, 4'b0010, 4'b0000);
    wait_frame(40);
    cnt_a = 0; cnt_b = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (an == 4'b1101) cnt_a++;
      if (an == 4'b1111 && cat == 8'hFF) cnt_b++;
    end
    check("blank_an1_seen", cnt_a, 0);
    check("blank_dark_slots", cnt_b, 4);

    // 6: reset while data is pending
    repeat (3) @(negedge clk);
    do_load(16'hFFFF, 4'b1111, 4'b0000, 4'b0000);
    check("mid_pend", {31'd0, pend}, 32'd1);
    rest = 1'b1;
    @(negedge clk);
    rest = 1'b0;
    check("rst_mid_pend", {31'd0, pend}, 32'd0);
    check("rst_mid_an", {28'd0, an}, 32'hF);
    wait_an(4'b1110, 40);
    check("rst_mid_cat", {24'd0, cat}, 32'hC0);

    // blink on digit 0: lit in 2 of every 4 frames with the macro, always otherwise
    do_load(16'h0000, 4'b0000, 4'b0000, 4'b0001);
    wait_frame(40);
    cnt_a = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (an == 4'b1110) cnt_a++;
    end
`ifdef SEG7_BLINK_EN
    check("blink_lit_cycles", cnt_a, 8);
`else
    check("blink_lit_cycles", cnt_a, 16);
`endif

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
